// File: rtl/mem_stage.sv
// RV32I memory-access stage: issues loads/stores on a req/gnt/rvalid port and emits one writeback bundle per instruction.
// Latency pass/fault 1, store 2+, load 3+ cycles; ex_ready only in IDLE, so upstream stalls for the whole access.
module mem_stage #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [XLEN-1:0] ex_alu_res,
    input  logic [XLEN-1:0] ex_rs2,
    input  logic [2:0]      ex_funct3,
    input  logic            ex_mem_en,
    input  logic            ex_memRW,
    input  logic [4:0]      ex_rd,
    input  logic            ex_wb_en,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_wstrb,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            wb_valid,
    output logic            wb_en,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            mem_fault
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;

    state_t          state_q;
    logic [XLEN-1:0] addr_q, wdata_q, wb_data_q;
    logic [3:0]      wstrb_q;
    logic [2:0]      funct3_q;
    logic [4:0]      rd_q;
    logic            we_q, wb_en_q, fault_q;

    logic [1:0]      off;
    logic            misalign, bad_f3, fault_d;
    logic [3:0]      wstrb_d;
    logic [XLEN-1:0] wdata_d, shifted, load_d;

    always_comb begin
        off      = ex_alu_res[1:0];
        misalign = (ex_funct3[1:0] == 2'b01 && off[0]) ||
                   (ex_funct3[1:0] == 2'b10 && off != 2'b00);
        bad_f3   = ex_memRW ? (ex_funct3 > 3'd2)
                            : (ex_funct3 == 3'd3 || ex_funct3 == 3'd6 || ex_funct3 == 3'd7);
        fault_d  = misalign || bad_f3;
        case (ex_funct3[1:0])
            2'b00:   begin wstrb_d = 4'b0001 << off; wdata_d = {4{ex_rs2[7:0]}};  end
            2'b01:   begin wstrb_d = 4'b0011 << off; wdata_d = {2{ex_rs2[15:0]}}; end
            default: begin wstrb_d = 4'hF;           wdata_d = ex_rs2;            end
        endcase
    end

    // Bring the addressed byte/half down to bit 0, then extend per funct3.
    always_comb begin
        shifted = dmem_rdata >> {addr_q[1:0], 3'b000};
        case (funct3_q)
            3'b000:  load_d = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
            3'b001:  load_d = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            3'b100:  load_d = {{(XLEN-8){1'b0}},         shifted[7:0]};
            3'b101:  load_d = {{(XLEN-16){1'b0}},        shifted[15:0]};
            default: load_d = shifted;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wb_data_q <= '0;
            wstrb_q   <= '0;
            funct3_q  <= '0;
            rd_q      <= '0;
            we_q      <= 1'b0;
            wb_en_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (ex_valid) begin
                    addr_q    <= ex_alu_res;
                    wb_data_q <= ex_alu_res;
                    funct3_q  <= ex_funct3;
                    rd_q      <= ex_rd;
                    we_q      <= ex_memRW;
                    wstrb_q   <= ex_memRW ? wstrb_d : 4'h0;
                    wdata_q   <= wdata_d;
                    if (!ex_mem_en) begin
                        wb_en_q <= ex_wb_en;
                        fault_q <= 1'b0;
                        state_q <= OUT;
                    end else if (fault_d) begin
                        wb_en_q <= 1'b0;
                        fault_q <= 1'b1;
                        state_q <= OUT;
                    end else begin
                        wb_en_q <= ex_memRW ? 1'b0 : ex_wb_en;
                        fault_q <= 1'b0;
                        state_q <= REQ;
                    end
                end
                REQ:  if (dmem_gnt) state_q <= we_q ? OUT : WAIT;
                WAIT: if (dmem_rvalid) begin
                    wb_data_q <= load_d;
                    state_q   <= OUT;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        ex_ready   = (state_q == IDLE);
        dmem_req   = (state_q == REQ);
        dmem_we    = dmem_req & we_q;
        dmem_wstrb = dmem_req ? wstrb_q : 4'h0;
        dmem_addr  = {addr_q[XLEN-1:2], 2'b00};
        dmem_wdata = wdata_q;
        wb_valid   = (state_q == OUT);
        wb_en      = wb_valid & wb_en_q;
        wb_rd      = rd_q;
        wb_data    = wb_data_q;
        mem_fault  = wb_valid & fault_q;
    end

endmodule
